// File: rtl/fsm_ab_seq_driver_if.sv
// Host/stimulus bundle for the (a,b)/(y0,y1) sequence driver.
// The slave modport is the driver itself; master is the host plus the FSM under test.
interface fsm_ab_seq_driver_if #(
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [15:0]       prog;
    logic [2:0]        len;
    logic [HOLD_W-1:0] hold;
    logic [CNT_W-1:0]  reps;
    logic              y0;
    logic              y1;
    logic              a;
    logic              b;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  y0_cnt;
    logic [CNT_W-1:0]  y1_cnt;

    modport slave (
        input  start, prog, len, hold, reps, y0, y1,
        output a, b, busy, done, y0_cnt, y1_cnt
    );

    modport master (
        output start, prog, len, hold, reps, y0, y1,
        input  a, b, busy, done, y0_cnt, y1_cnt
    );
endinterface

// File: rtl/fsm_ab_seq_driver.sv
// Plays up to 8 (a,b) steps with per-step hold and whole-sequence repeat,
// counting Moore (y1) and Mealy (y0) responses while driving.
module fsm_ab_seq_driver #(
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    fsm_ab_seq_driver_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t            state_q;
    logic [15:0]       prog_q;
    logic [2:0]        len_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  reps_q;
    logic [2:0]        step_q;
    logic [HOLD_W-1:0] hcnt_q;
    logic [CNT_W-1:0]  rep_q;
    logic              a_q;
    logic              b_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  y0_cnt_q;
    logic [CNT_W-1:0]  y1_cnt_q;

    logic              stepEnd;
    logic              lastStep;
    logic              lastRep;
    logic              finish;
    logic [2:0]        step_d;
    logic [1:0]        stepBits_d;
    logic [CNT_W-1:0]  y0_cnt_d;
    logic [CNT_W-1:0]  y1_cnt_d;

    // Next step index and its stimulus bits, so a/b can be registered one cycle ahead.
    always_comb begin
        stepEnd    = (hcnt_q == hold_q);
        lastStep   = (step_q == len_q);
        lastRep    = (rep_q == reps_q);
        finish     = stepEnd && lastStep && lastRep;
        step_d     = step_q;
        if (stepEnd) begin
            step_d = lastStep ? 3'd0 : step_q + 3'd1;
        end
        stepBits_d = prog_q[{step_d, 1'b0} +: 2];
        y0_cnt_d   = (bus.y0 && (y0_cnt_q != '1)) ? y0_cnt_q + CNT_W'(1) : y0_cnt_q;
        y1_cnt_d   = (bus.y1 && (y1_cnt_q != '1)) ? y1_cnt_q + CNT_W'(1) : y1_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            prog_q   <= '0;
            len_q    <= '0;
            hold_q   <= '0;
            reps_q   <= '0;
            step_q   <= '0;
            hcnt_q   <= '0;
            rep_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y0_cnt_q <= '0;
            y1_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        prog_q   <= bus.prog;
                        len_q    <= bus.len;
                        hold_q   <= bus.hold;
                        reps_q   <= bus.reps;
                        step_q   <= '0;
                        hcnt_q   <= '0;
                        rep_q    <= '0;
                        y0_cnt_q <= '0;
                        y1_cnt_q <= '0;
                        a_q      <= bus.prog[1];
                        b_q      <= bus.prog[0];
                        busy_q   <= 1'b1;
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    y0_cnt_q <= y0_cnt_d;
                    y1_cnt_q <= y1_cnt_d;
                    if (!stepEnd) begin
                        hcnt_q <= hcnt_q + HOLD_W'(1);
                    end else begin
                        hcnt_q <= '0;
                        step_q <= step_d;
                        if (lastStep && !lastRep) begin
                            rep_q <= rep_q + CNT_W'(1);
                        end
                    end
                    if (finish) begin
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        a_q <= stepBits_d[1];
                        b_q <= stepBits_d[0];
                    end
                end
                DONE: begin
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.y0_cnt = y0_cnt_q;
    assign bus.y1_cnt = y1_cnt_q;

endmodule
